// File: rtl/core_sequencer_if.sv
// Instruction and data memory valid/ready handshakes between the core sequencer
// (master) and the memory system (slave).
interface core_sequencer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32 subset core (ADD/ADDI/LUI/JALR/LW/SW).
// Owns pc/instr, sequences fetch, data access and writeback, and halts on faults.
module core_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    core_sequencer_if.master bus,
    input  logic [31:0]      ex_result,
    input  logic [31:0]      ex_branch_target,
    input  logic             ex_branch_enable,
    input  logic [31:0]      rs2_data,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             retire,
    output logic [31:0]      instret,
    output logic             halted,
    output logic             illegal_instr,
    output logic             misaligned,
    output logic             bus_error
);
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [15:0] WAIT_LIMIT = (MEM_TIMEOUT == 0) ? 16'd0 : 16'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        FETCH_REQ, FETCH_WAIT, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, HALT
    } state_t;

    state_t      state, state_next;
    logic [15:0] wait_cnt;
    logic [31:0] wb_data, pc_next, dmem_addr, dmem_wdata;
    logic        dmem_we;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store, is_legal, is_mem, timeout_hit;
    logic        set_illegal, set_misaligned, set_bus_error;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_load  = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_store = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_mem   = is_load || is_store;
    assign is_legal = is_mem || (opcode == 7'b0110011) || (opcode == 7'b0010011)
                   || (opcode == 7'b0110111) || (opcode == 7'b1100111);

    // wait_cnt holds the number of wait cycles already spent before this one
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH_REQ;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        set_illegal    = 1'b0;
        set_misaligned = 1'b0;
        set_bus_error  = 1'b0;
        case (state)
            FETCH_REQ:  if (bus.imem_req_ready) state_next = FETCH_WAIT;
            FETCH_WAIT: begin
                if (bus.imem_rsp_valid) state_next = EXECUTE;
                else if (timeout_hit) begin
                    state_next    = HALT;
                    set_bus_error = 1'b1;
                end
            end
            EXECUTE: begin
                if (!is_legal) begin
                    state_next  = HALT;
                    set_illegal = 1'b1;
                end else if (is_mem) begin
                    if (ex_result[1:0] != 2'b00) begin
                        state_next     = HALT;
                        set_misaligned = 1'b1;
                    end else begin
                        state_next = MEM_REQ;
                    end
                end else begin
                    state_next = WRITEBACK;
                end
            end
            MEM_REQ:  if (bus.dmem_req_ready) state_next = MEM_WAIT;
            MEM_WAIT: begin
                if (bus.dmem_rsp_valid) state_next = WRITEBACK;
                else if (timeout_hit) begin
                    state_next    = HALT;
                    set_bus_error = 1'b1;
                end
            end
            WRITEBACK: state_next = FETCH_REQ;
            default:   state_next = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            instr         <= NOP;
            instret       <= '0;
            pc_next       <= '0;
            wb_data       <= '0;
            wait_cnt      <= '0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_we       <= 1'b0;
            illegal_instr <= 1'b0;
            misaligned    <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            if ((state_next != state) || !((state == FETCH_WAIT) || (state == MEM_WAIT)))
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 16'd1;

            case (state)
                FETCH_WAIT: if (bus.imem_rsp_valid) instr <= bus.imem_rsp_data;
                EXECUTE: begin
                    pc_next <= ex_branch_enable ? ex_branch_target : pc + 32'd4;
                    if (is_mem) begin
                        if (ex_result[1:0] == 2'b00) begin
                            dmem_addr  <= ex_result;
                            dmem_we    <= is_store;
                            dmem_wdata <= rs2_data;
                        end
                    end else begin
                        wb_data <= ex_result;
                    end
                end
                MEM_WAIT: if (bus.dmem_rsp_valid && !dmem_we) wb_data <= bus.dmem_rsp_data;
                WRITEBACK: begin
                    pc      <= pc_next;
                    instret <= instret + 32'd1;
                end
                default: ;
            endcase

            if (set_illegal)    illegal_instr <= 1'b1;
            if (set_misaligned) misaligned    <= 1'b1;
            if (set_bus_error)  bus_error     <= 1'b1;
        end
    end

    // all strobes and valids decode from state only, never from a ready input
    assign bus.imem_req_valid = (state == FETCH_REQ);
    assign bus.imem_addr      = pc;
    assign bus.dmem_req_valid = (state == MEM_REQ);
    assign bus.dmem_we        = dmem_we;
    assign bus.dmem_addr      = dmem_addr;
    assign bus.dmem_wdata     = dmem_wdata;

    assign retire   = (state == WRITEBACK);
    assign rf_we    = retire && !is_store && (instr[11:7] != 5'd0);
    assign rf_waddr = instr[11:7];
    assign rf_wdata = wb_data;
    assign halted   = (state == HALT);
endmodule

// File: tb/tb_core_sequencer.sv
// Lockstep bench for core_sequencer: directed and randomized instructions are
// checked against a transaction-level model of fetch/execute/memory/writeback.
module tb_core_sequencer;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_result, ex_branch_target, rs2_data;
    logic        ex_branch_enable;
    logic [31:0] pc, instr, rf_wdata, instret;
    logic [4:0]  rf_waddr;
    logic        rf_we, retire, halted, illegal_instr, misaligned, bus_error;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_pc, m_instret;

    always #5 clk = ~clk;

    core_sequencer_if bus();

    core_sequencer #(.RESET_PC(RST_PC), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ex_result(ex_result), .ex_branch_target(ex_branch_target),
        .ex_branch_enable(ex_branch_enable), .rs2_data(rs2_data),
        .pc(pc), .instr(instr), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire(retire), .instret(instret), .halted(halted),
        .illegal_instr(illegal_instr), .misaligned(misaligned), .bus_error(bus_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(input logic [31:0] ins);
        logic [6:0] opc;
        logic [2:0] f3;
        opc = ins[6:0];
        f3  = ins[14:12];
        return (opc == 7'h33) || (opc == 7'h13) || (opc == 7'h37) || (opc == 7'h67)
            || (((opc == 7'h03) || (opc == 7'h23)) && (f3 == 3'd2));
    endfunction

    task automatic idle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.dmem_req_ready = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
        bus.dmem_rsp_data  = '0;
        ex_result          = '0;
        ex_branch_target   = '0;
        ex_branch_enable   = 1'b0;
        rs2_data           = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instret", instret, 0);
        chk("rst_flags", {halted, illegal_instr, misaligned, bus_error, rf_we, retire,
                          bus.dmem_req_valid}, 0);
        rst       = 1'b0;
        m_pc      = RST_PC;
        m_instret = 0;
    endtask

    // One instruction from FETCH_REQ to the cycle after writeback (or to a halt).
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] exr, input logic [31:0] tgt,
                             input logic be, input logic [31:0] rs2, input logic [31:0] ld,
                             input int iw, input int irw, input int dw, input int drw);
        bit          lg, mem, st, exp_we;
        int          steps;
        logic [31:0] npc;
        lg    = m_legal(ins);
        mem   = lg && ((ins[6:0] == 7'h03) || (ins[6:0] == 7'h23));
        st    = lg && (ins[6:0] == 7'h23);
        npc   = be ? tgt : m_pc + 32'd4;
        steps = 0;

        chk("fetch_req", {bus.imem_req_valid, bus.imem_addr}, {1'b1, m_pc});
        bus.imem_req_ready = 1'b0;
        repeat (iw) begin
            step(); steps++;
            chk("fetch_hold", {bus.imem_req_valid, bus.imem_addr}, {1'b1, m_pc});
        end
        bus.imem_req_ready = 1'b1;
        step(); steps++;
        bus.imem_req_ready = 1'b0;
        chk("fetch_drop", bus.imem_req_valid, 0);
        repeat (irw) begin step(); steps++; end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = ins;
        ex_result          = exr;
        ex_branch_target   = tgt;
        ex_branch_enable   = be;
        rs2_data           = rs2;
        step(); steps++;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        chk("instr_latch", instr, ins);
        step(); steps++;

        if (!lg) begin
            chk("illegal_halt", {halted, illegal_instr, misaligned, bus_error}, 4'b1100);
            chk("illegal_noreq", {bus.imem_req_valid, bus.dmem_req_valid}, 2'b00);
            return;
        end
        if (mem && (exr[1:0] != 2'b00)) begin
            chk("misalign_halt", {halted, illegal_instr, misaligned, bus_error}, 4'b1010);
            chk("misalign_noreq", bus.dmem_req_valid, 0);
            return;
        end
        if (mem) begin
            bus.dmem_req_ready = 1'b0;
            chk("dmem_ctl", {bus.dmem_req_valid, bus.dmem_we}, {1'b1, st});
            chk("dmem_addr", bus.dmem_addr, exr);
            chk("dmem_wdata", bus.dmem_wdata, rs2);
            repeat (dw) begin
                step(); steps++;
                chk("dmem_hold_ctl", {bus.dmem_req_valid, bus.dmem_we}, {1'b1, st});
                chk("dmem_hold", {bus.dmem_addr, bus.dmem_wdata}, {exr, rs2});
            end
            bus.dmem_req_ready = 1'b1;
            step(); steps++;
            bus.dmem_req_ready = 1'b0;
            chk("dmem_drop", bus.dmem_req_valid, 0);
            repeat (drw) begin step(); steps++; end
            bus.dmem_rsp_valid = 1'b1;
            bus.dmem_rsp_data  = ld;
            step(); steps++;
            bus.dmem_rsp_valid = 1'b0;
        end

        exp_we = !st && (ins[11:7] != 5'd0);
        chk("wb_strobes", {retire, rf_we}, {1'b1, exp_we});
        if (exp_we) chk("rf_write", {rf_waddr, rf_wdata}, {ins[11:7], (mem ? ld : exr)});
        chk("latency", steps, (mem ? 5 + dw + drw : 3) + iw + irw);
        step();
        m_pc      = npc;
        m_instret = m_instret + 32'd1;
        chk("next_pc", {pc, instret}, {npc, m_instret});
        chk("post_wb", {retire, rf_we, halted}, 3'b000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        m_pc      = RST_PC;
        m_instret = 0;
        do_reset();

        // ADDI x1,x0,5 / LW x2,0(x1) / SW x2,4(x1) / ADD x3,x1,x2
        run_instr(32'h0050_0093, 32'd5, 32'h0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);
        run_instr(32'h0000_A103, 32'h100, 32'h0, 1'b0, 32'h1234, 32'hDEAD_BEEF, 0, 0, 3, 0);
        run_instr(32'h0020_A223, 32'h104, 32'h0, 1'b0, 32'hA5A5_A5A5, 32'h0, 1, 1, 0, 2);
        run_instr(32'h0020_81B3, 32'h77, 32'h0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);
        chk("jalr_at_0x10", pc, 32'h10);
        // JALR x1,0(x5) then the same with rd=0
        run_instr(32'h0002_80E7, 32'h14, 32'h200, 1'b1, 32'h0, 32'h0, 0, 0, 0, 0);
        run_instr(32'h0002_8067, 32'h204, 32'h300, 1'b1, 32'h0, 32'h0, 0, 0, 0, 0);
        run_instr(32'hABCD_E2B7, 32'hABCD_E000, 32'h0, 1'b0, 32'h0, 32'h0, 2, 0, 0, 0);
        // responses arriving exactly on the last allowed wait cycle
        run_instr(32'h0070_0393, 32'd7, 32'h0, 1'b0, 32'h0, 32'h0, 0, 7, 0, 0);
        run_instr(32'h0000_A103, 32'h8, 32'h0, 1'b0, 32'h0, 32'h1357_9BDF, 0, 7, 0, 7);

        // illegal opcode halts and stays quiet
        run_instr(32'h0000_007F, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);
        bus.imem_req_ready = 1'b1;
        repeat (20) begin
            step();
            chk("halt_hold", {bus.imem_req_valid, bus.dmem_req_valid, halted, illegal_instr, instret},
                {2'b00, 2'b11, m_instret});
            chk("halt_pc", {pc, instr}, {m_pc, 32'h0000_007F});
        end
        do_reset();

        // misaligned load
        run_instr(32'h0000_A103, 32'h102, 32'h0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);
        step();
        chk("misalign_hold", {halted, misaligned, bus.dmem_req_valid, pc}, {3'b110, m_pc});
        do_reset();

        // fetch response that never arrives
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        repeat (7) begin
            step();
            chk("timeout_wait", {halted, bus_error}, 2'b00);
        end
        step();
        chk("timeout_halt", {halted, illegal_instr, misaligned, bus_error}, 4'b1001);
        chk("timeout_frozen", {pc, instr}, {RST_PC, 32'h0000_0013});
        do_reset();

        // reset during MEM_WAIT, then a stale data response
        run_instr(32'h0050_0093, 32'd5, 32'h0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_A103;
        ex_result          = 32'h40;
        step();
        bus.imem_rsp_valid = 1'b0;
        step();
        bus.dmem_req_ready = 1'b1;
        step();
        bus.dmem_req_ready = 1'b0;
        chk("in_mem_wait", {bus.dmem_req_valid, retire}, 2'b00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_pc      = RST_PC;
        m_instret = 0;
        bus.dmem_rsp_valid = 1'b1;
        bus.dmem_rsp_data  = 32'hBAD0_BAD0;
        repeat (2) begin
            step();
            chk("stale_rsp", {bus.imem_req_valid, bus.dmem_req_valid, rf_we, retire, halted},
                5'b10000);
            chk("stale_state", {pc, instret}, {RST_PC, 32'h0});
        end
        bus.dmem_rsp_valid = 1'b0;
        run_instr(32'h0050_0093, 32'd5, 32'h0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0);

        // randomized legal instruction stream
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] ins, exr, tgt;
            logic        be;
            kind = int'($urandom_range(0, 5));
            ins  = $urandom;
            case (kind)
                0: ins[6:0] = 7'h33;
                1: ins[6:0] = 7'h13;
                2: ins[6:0] = 7'h37;
                3: ins[6:0] = 7'h67;
                4: begin ins[6:0] = 7'h03; ins[14:12] = 3'd2; end
                default: begin ins[6:0] = 7'h23; ins[14:12] = 3'd2; end
            endcase
            exr = $urandom;
            if (kind >= 4) exr[1:0] = 2'b00;
            tgt = $urandom & 32'hFFFF_FFFC;
            be  = (kind == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_instr(ins, exr, tgt, be, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the RV32 subset core: ADD, ADDI, LUI, JALR, LW, SW. Owns PC and instruction register, issues instruction and data memory requests over valid/ready handshakes, and consumes the combinational execute stage's result and branch outputs. Drives register-file writeback and retires one instruction at a time. Halts on illegal instruction, misaligned access or memory timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
MEM_TIMEOUT, 255, max wait cycles for a memory response (1..65535); 0 disables the timeout

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  fetch request accepted
imem_addr  out  32  fetch address (= pc)
imem_rsp_valid  in  1  fetch data valid
imem_rsp_data  in  32  fetched instruction
dmem_req_valid  out  1  data request
dmem_req_ready  in  1  data request accepted
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  32  data address
dmem_wdata  out  32  store data
dmem_rsp_valid  in  1  load data valid / store acknowledge
dmem_rsp_data  in  32  load data
ex_result  in  32  execute result (ALU / address / link)
ex_branch_target  in  32  execute jump target
ex_branch_enable  in  1  execute jump taken
rs2_data  in  32  register-file read port 2 (store data)
pc  out  32  current PC
instr  out  32  instruction register (feeds decode/execute)
rf_we  out  1  register write strobe
rf_waddr  out  5  destination register
rf_wdata  out  32  writeback data
retire  out  1  one-cycle pulse per retired instruction
instret  out  32  retired-instruction count (wraps)
halted  out  1  in HALT
illegal_instr  out  1  halt cause: illegal
misaligned  out  1  halt cause: misaligned
bus_error  out  1  halt cause: timeout

Behaviour:
- Reset (rst high at edge) has priority over everything and applies in any state. Results: state FETCH_REQ, pc=RESET_PC, instr=32'h0000_0013, instret=0. Every strobe, valid and cause flag is 0. Internal wait counter is 0. Responses still in flight from before reset are ignored, since rsp inputs are only sampled in *_WAIT states.
- States: FETCH_REQ, FETCH_WAIT, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, HALT.
- FETCH_REQ: imem_req_valid=1 and imem_addr=pc, held stable until accepted. On imem_req_ready, go to FETCH_WAIT.
- FETCH_WAIT: on imem_rsp_valid, latch instr and go to EXECUTE. Responses are accepted no earlier than the cycle after acceptance.
- EXECUTE (1 cycle): decode uses opcode=instr[6:0] and funct3=instr[14:12].
  - Legal: 0110011, 0010011, 0110111, 1100111, plus 0000011 and 0100011 only with funct3=010. Anything else goes to HALT with illegal_instr=1.
  - Next PC: pc_next = ex_branch_enable ? ex_branch_target : pc+4 (32-bit wrap).
  - Load/store: if ex_result[1:0]≠0, go to HALT with misaligned=1. Otherwise latch dmem_addr=ex_result, dmem_we (1 for 0100011), dmem_wdata=rs2_data, and go to MEM_REQ.
  - All other legal opcodes: latch wb_data=ex_result and go to WRITEBACK.
- MEM_REQ: dmem_req_valid=1 with addr, we and wdata stable until accepted. On dmem_req_ready, go to MEM_WAIT.
- MEM_WAIT: on dmem_rsp_valid, go to WRITEBACK. For a load, also latch wb_data=dmem_rsp_data.
- Timeout: the wait counter counts cycles in FETCH_WAIT and MEM_WAIT and clears on state entry. With MEM_TIMEOUT≠0, reaching MEM_TIMEOUT without a response goes to HALT with bus_error=1. A response in the same cycle as the limit wins.
- WRITEBACK (1 cycle):
  - rf_we=1, rf_waddr=instr[11:7], rf_wdata=wb_data. rf_we is forced 0 for stores and for rd=0.
  - pc<=pc_next, instret+1, retire=1, then go to FETCH_REQ.
- HALT: terminal until rst. No requests; halted=1; cause flag held; pc and instr frozen at the faulting instruction.
- Latency with zero-wait memory: ALU/LUI/JALR take 4 cycles per instruction; LW/SW take 6.
- rf_we, retire and the valid outputs are registered or state-decoded; none depends combinationally on a ready input.

Test Plan:
1. Reset, then imem returns ADDI x1,x0,5 (0x00500093), with ex_result=5 and ready/rsp at zero wait → 4th cycle after reset release has rf_we=1, waddr=1, wdata=5, retire=1; then pc=4, instret=1.
2. LW x2,0(x1) with ex_result=0x100 and dmem_req_ready low for 3 cycles → dmem_req_valid held 4 cycles with addr 0x100 stable, we=0. rsp_data 0xDEADBEEF → rf write x2=0xDEADBEEF, pc+4.
3. SW with ex_result=0x104, rs2_data=0xA5A5A5A5 → dmem_we=1, wdata=0xA5A5A5A5; after ack, retire=1, rf_we=0, pc+4.
4. JALR at pc=0x10 with ex_result=0x14, branch_target=0x200, branch_enable=1, rd=1 → x1=0x14, next fetch at 0x200. Same instruction with rd=0 → rf_we stays 0.
5. Instruction 0x0000007F → HALT with illegal_instr=1, no further imem_req_valid for 20 cycles, instret unchanged. rst → fetch resumes at RESET_PC with flags cleared.
6. LW with ex_result=0x102 → HALT with misaligned=1 and no dmem request. With MEM_TIMEOUT=8 and a fetch response never arriving → bus_error=1 after 8 wait cycles. Assert rst mid-MEM_WAIT, then a late dmem_rsp_valid → ignored, FSM in FETCH_REQ.
